// File: rtl/spi_regfile_pkg.sv
// Shared definitions for the SPI register-file peripheral: FSM state encoding,
// R/W bit values and the frame-length helper.
// No logic; imported by spi_regfile_peripheral.
package spi_regfile_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,   // waiting for chip select
        ST_CMD  = 3'd1,   // shifting R/W bit and address
        ST_DATA = 3'd2,   // shifting data field
        ST_DONE = 3'd3,   // frame complete, waiting for ncs rise
        ST_ERR  = 3'd4    // frame too long, discard on ncs rise
    } spi_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Total frame length: R/W bit + address + data.
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser followed by one history flop for edge detection.
// Ports: clk, rst_n (async active-low), d (async input);
//        level (synchronised d), rise/fall (1-clk pulses on synchronised edges).
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0   // idle level of the input, avoids a false edge out of reset
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    // sh[0], sh[1] form the synchroniser; sh[2] is the previous synchronised value.
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= {3{RST_VAL}};
        end else begin
            sh <= {sh[1:0], d};
        end
    end

    assign level = sh[1];
    assign rise  = sh[1] & ~sh[2];
    assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 target giving a host read/write access to a bank of control registers.
// Frame: R/W (1 = write), ADDR_W address bits, DATA_W data bits, MSB first; writes commit on ncs rise.
// Ports: clk, rst_n, sclk/copi/ncs (SPI in), cipo/cipo_oe (SPI out), regs_o (flat bank),
//        wr_stb (per-register commit pulse), frame_err (discarded-frame pulse).
// Optional feature: SPI_READBACK_EN enables the read path (cipo shifter); without it
// cipo/cipo_oe are tied low and read frames are consumed silently.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int                NUM_REGS  = 5,
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]        wr_stb,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [ADDR_W:0] NUM_REGS_L = NUM_REGS[ADDR_W:0];

    // ---------------- synchronisers ----------------
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl,  ncs_rise,  ncs_fall;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(copi),
        .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));

    // ncs idles high, so its synchroniser resets high to avoid a spurious edge.
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));

    // Only edges of sclk/ncs and the level of copi drive the frame logic.
    logic sync_unused;
`ifdef SPI_READBACK_EN
    assign sync_unused = &{sclk_lvl, copi_rise, copi_fall};
`else
    assign sync_unused = &{sclk_lvl, copi_rise, copi_fall, ncs_lvl};
`endif

    // ---------------- frame state ----------------
    spi_state_t         state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0]  cmd_sr;     // previous ADDR_W command bits
    logic [DATA_W-1:0]  data_sr;
    logic               rw;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    // Command word including the bit being sampled now; used on the last CMD edge
    // so rw/addr (and the read value) are available without an extra cycle.
    logic [ADDR_W:0]    cmd_nx;
    assign cmd_nx = {cmd_sr, copi_lvl};

    logic addr_ok;
    assign addr_ok = ({1'b0, addr} < NUM_REGS_L);

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] rd_buf;
    logic [DATA_W-1:0] rd_val;

    // Out-of-range reads return zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_nx[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_val = regs[i];
            end
        end
    end
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            data_sr   <= '0;
            rw        <= 1'b0;
            addr      <= '0;
            wr_stb    <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
`ifdef SPI_READBACK_EN
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
            rd_buf    <= '0;
`endif
        end else begin
            wr_stb    <= '0;
            frame_err <= 1'b0;
`ifdef SPI_READBACK_EN
            cipo_oe   <= ~ncs_lvl;
`endif
            if (ncs_rise) begin
                // End of frame: commit or discard, always back to IDLE.
                state <= ST_IDLE;
`ifdef SPI_READBACK_EN
                cipo  <= 1'b0;
`endif
                case (state)
                    ST_CMD, ST_DATA, ST_ERR: frame_err <= 1'b1;
                    ST_DONE: begin
                        unique case (rw)
                            RW_WRITE: begin
                                if (addr_ok) begin
                                    for (int i = 0; i < NUM_REGS; i++) begin
                                        if (addr == ADDR_W'(i)) begin
                                            regs[i]   <= data_sr;
                                            wr_stb[i] <= 1'b1;
                                        end
                                    end
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end
                            RW_READ: ;  // a correctly sized read ends cleanly
                        endcase
                    end
                    default: ;
                endcase
            end else if (ncs_fall && state == ST_IDLE) begin
                state   <= ST_CMD;
                bit_cnt <= '0;
                cmd_sr  <= '0;
                data_sr <= '0;
            end else if (sclk_rise) begin
                case (state)
                    ST_CMD: begin
                        cmd_sr <= cmd_nx[ADDR_W-1:0];
                        if (bit_cnt == CNT_W'(ADDR_W)) begin
                            rw      <= cmd_nx[ADDR_W];
                            addr    <= cmd_nx[ADDR_W-1:0];
                            bit_cnt <= '0;
                            state   <= ST_DATA;
`ifdef SPI_READBACK_EN
                            // MSB goes out straight away so it is valid for the first data edge.
                            if (cmd_nx[ADDR_W] == RW_READ) begin
                                rd_buf <= rd_val;
                                cipo   <= rd_val[DATA_W-1];
                            end
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        data_sr <= {data_sr[DATA_W-2:0], copi_lvl};
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            state <= ST_DONE;
`ifdef SPI_READBACK_EN
                            cipo  <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_ERR;
                    default: ;
                endcase
`ifdef SPI_READBACK_EN
            end else if (sclk_fall && state == ST_DATA && rw == RW_READ) begin
                // The falling edge that closes the command phase precedes any data
                // sample, so the MSB is held there; later falls advance one bit.
                if (bit_cnt != '0) begin
                    cipo   <= rd_buf[DATA_W-2];
                    rd_buf <= rd_buf << 1;
                end
`endif
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule
